mux_n_1_sync: RTL and testbench

- Parametrised, registered N-to-1 selector for the radar simulator signal path (trigger, clutter and target channels).
- Channel changes are requested through a valid/ready handshake.
- A requested change takes effect only at the next frame-boundary strobe, followed by a guard interval of forced-zero output.
- Result: no runt pulses or mixed-source samples on the output.

---
 rtl/mux_n_1_sync.sv | 137 +++++++++++++
 tb/tb_mux_n_1_sync.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_sync.sv
// Registered N-to-1 channel selector. Channel switches are requested by handshake,
// deferred to the next frame strobe and followed by GUARD forced-zero output cycles.
module mux_n_1_sync #(
    parameter  int N_CH        = 4,
    parameter  int W           = 1,
    parameter  int GUARD       = 2,
    parameter  int DEFAULT_SEL = 0,
    localparam int SEL_W       = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_CH*W-1:0] M_IN,
    input  logic [SEL_W-1:0]  M_SEL,
    input  logic              M_SEL_VALID,
    output logic              M_SEL_READY,
    input  logic              M_SYNC,
    output logic [W-1:0]      M_OUT,
    output logic [SEL_W-1:0]  M_ACTIVE,
    output logic              M_BUSY,
    output logic              M_ERR
);

    localparam logic [1:0]       S_PASS  = 2'd0;
    localparam logic [1:0]       S_WAIT  = 2'd1;
    localparam logic [1:0]       S_BLANK = 2'd2;
    localparam logic [SEL_W:0]   N_CH_X  = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SEL);
    localparam logic [7:0]       GUARD_M1 = (GUARD > 0) ? 8'(GUARD - 1) : 8'd0;

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [SEL_W-1:0] pend_q, pend_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [W-1:0]     out_q, out_d;
    logic             err_q, err_d;
    logic             zero_q, zero_d;
    logic [W-1:0]     sel_data;
    logic             accept;
    logic             sel_oob;

    // Only in-range indices are decoded, so a bad code can never select data.
    always_comb begin
        sel_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (active_q == SEL_W'(c)) begin
                sel_data = M_IN[c*W +: W];
            end
        end
    end

    assign accept  = M_SEL_VALID && (state_q == S_PASS);
    assign sel_oob = ({1'b0, M_SEL} >= N_CH_X);

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        out_d    = sel_data;
        err_d    = 1'b0;
        zero_d   = 1'b0;
        case (state_q)
            S_PASS: begin
                if (accept) begin
                    if (sel_oob) begin
                        err_d = 1'b1;
                    end else if (M_SEL != active_q) begin
                        pend_d  = M_SEL;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (M_SYNC) begin
                    if (GUARD == 0) begin
                        active_d = pend_q;
                        state_d  = S_PASS;
                    end else begin
                        out_d  = '0;
                        zero_d = 1'b1;
                        if (GUARD == 1) begin
                            active_d = pend_q;
                            cnt_d    = 8'd0;
                            state_d  = S_PASS;
                        end else begin
                            cnt_d   = GUARD_M1;
                            state_d = S_BLANK;
                        end
                    end
                end
            end
            S_BLANK: begin
                out_d  = '0;
                zero_d = 1'b1;
                // Leave on the edge that writes the last zero so exactly GUARD zeros are emitted.
                if (cnt_q <= 8'd1) begin
                    active_d = pend_q;
                    cnt_d    = 8'd0;
                    state_d  = S_PASS;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_PASS;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_PASS;
            active_q <= DEF_SEL;
            pend_q   <= '0;
            cnt_q    <= 8'd0;
            out_q    <= '0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
        end
    end

    // BUSY also covers the final zero cycle, after READY has already returned.
    assign M_OUT       = out_q;
    assign M_ACTIVE    = active_q;
    assign M_SEL_READY = (state_q == S_PASS);
    assign M_BUSY      = (state_q != S_PASS) || zero_q;
    assign M_ERR       = err_q;

endmodule

// File: tb/tb_mux_n_1_sync.sv
// Directed bench: GUARD=2 and GUARD=0 selectors run in lockstep, plus a 3-channel
// instance for out-of-range and no-op requests.
module tb_mux_n_1_sync;

    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   min4 = 32'h44332211;
    logic [23:0]   min3 = 24'h332211;
    logic [SW-1:0] sel, c_sel;
    logic          vld, c_vld, sync;

    logic [7:0]    a_out, b_out, c_out;
    logic [SW-1:0] a_act, b_act, c_act;
    logic          a_rdy, b_rdy, c_rdy;
    logic          a_busy, b_busy, c_busy;
    logic          a_err, b_err, c_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_n_1_sync #(.N_CH(4), .W(8), .GUARD(2), .DEFAULT_SEL(2)) u_a (
        .CLK(clk), .RST(rst), .M_IN(min4), .M_SEL(sel), .M_SEL_VALID(vld),
        .M_SEL_READY(a_rdy), .M_SYNC(sync), .M_OUT(a_out), .M_ACTIVE(a_act),
        .M_BUSY(a_busy), .M_ERR(a_err)
    );

    mux_n_1_sync #(.N_CH(4), .W(8), .GUARD(0), .DEFAULT_SEL(2)) u_b (
        .CLK(clk), .RST(rst), .M_IN(min4), .M_SEL(sel), .M_SEL_VALID(vld),
        .M_SEL_READY(b_rdy), .M_SYNC(sync), .M_OUT(b_out), .M_ACTIVE(b_act),
        .M_BUSY(b_busy), .M_ERR(b_err)
    );

    mux_n_1_sync #(.N_CH(3), .W(8), .GUARD(2), .DEFAULT_SEL(2)) u_c (
        .CLK(clk), .RST(rst), .M_IN(min3), .M_SEL(c_sel), .M_SEL_VALID(c_vld),
        .M_SEL_READY(c_rdy), .M_SYNC(sync), .M_OUT(c_out), .M_ACTIVE(c_act),
        .M_BUSY(c_busy), .M_ERR(c_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sel = '0; vld = 1'b0; sync = 1'b0; c_sel = '0; c_vld = 1'b0;

        // Reset / default
        tick(); tick();
        chk("rst_out", a_out, 8'h00);
        chk("rst_act", a_act, 2);
        chk("rst_rdy", a_rdy, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_err", a_err, 0);
        rst = 1'b0;
        tick();
        chk("rel_out", a_out, 8'h33);
        chk("rel_act", a_act, 2);

        // Deferred switch to channel 0, M_SYNC five cycles after accept
        sel = 2'd0; vld = 1'b1;
        tick();
        vld = 1'b0;
        chk("acc_busy", a_busy, 1);
        chk("acc_rdy", a_rdy, 0);
        chk("acc_out", a_out, 8'h33);
        chk("acc_b_busy", b_busy, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wait_out", a_out, 8'h33);
            chk("wait_busy", a_busy, 1);
            chk("wait_rdy", a_rdy, 0);
            chk("wait_b_out", b_out, 8'h33);
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("s0_out", a_out, 8'h00);
        chk("s0_busy", a_busy, 1);
        chk("s0_rdy", a_rdy, 0);
        chk("s0_act", a_act, 2);
        chk("g0_s0_out", b_out, 8'h33);
        chk("g0_s0_act", b_act, 0);
        chk("g0_s0_busy", b_busy, 0);
        tick();
        chk("s1_out", a_out, 8'h00);
        chk("s1_busy", a_busy, 1);
        chk("s1_act", a_act, 0);
        chk("s1_rdy", a_rdy, 1);
        chk("g0_s1_out", b_out, 8'h11);
        tick();
        chk("s2_out", a_out, 8'h11);
        chk("s2_busy", a_busy, 0);
        chk("s2_err", a_err, 0);

        // Sync coincident with accept is ignored; VALID ignored while waiting
        sel = 2'd3; vld = 1'b1; sync = 1'b1;
        tick();
        sync = 1'b0; sel = 2'd1;
        chk("co_busy", a_busy, 1);
        chk("co_out", a_out, 8'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_act", a_act, 0);
            chk("hold_busy", a_busy, 1);
            chk("hold_out", a_out, 8'h11);
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("hs_out", a_out, 8'h00);
        chk("hs_b_act", b_act, 3);
        chk("hs_b_out", b_out, 8'h11);
        tick();
        chk("ret_act", a_act, 3);
        chk("ret_rdy", a_rdy, 1);
        chk("ret_out", a_out, 8'h00);
        chk("ret_b_busy", b_busy, 1);
        chk("ret_b_out", b_out, 8'h44);
        tick();
        vld = 1'b0;
        chk("req2_busy", a_busy, 1);
        chk("req2_rdy", a_rdy, 0);
        chk("req2_act", a_act, 3);
        chk("req2_out", a_out, 8'h44);

        // Reset during the first zero cycle discards the pending switch
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("bl_out", a_out, 8'h00);
        chk("bl_busy", a_busy, 1);
        rst = 1'b1;
        tick();
        chk("mrst_act", a_act, 2);
        chk("mrst_busy", a_busy, 0);
        chk("mrst_out", a_out, 8'h00);
        chk("mrst_rdy", a_rdy, 1);
        rst = 1'b0;
        tick();
        chk("post_out", a_out, 8'h33);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("post_act", a_act, 2);
        chk("post_busy", a_busy, 0);
        chk("post_out2", a_out, 8'h33);

        // Out-of-range and no-op requests on the 3-channel instance
        c_sel = 2'd3; c_vld = 1'b1;
        tick();
        c_vld = 1'b0;
        chk("oob_err", c_err, 1);
        chk("oob_act", c_act, 2);
        chk("oob_busy", c_busy, 0);
        tick();
        chk("oob_err_clr", c_err, 0);
        c_sel = 2'd2; c_vld = 1'b1;
        tick();
        c_vld = 1'b0;
        chk("noop_err", c_err, 0);
        chk("noop_busy", c_busy, 0);
        chk("noop_rdy", c_rdy, 1);
        chk("noop_act", c_act, 2);
        chk("noop_out", c_out, 8'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
